bb8051_xdata_if: RTL and testbench

//   External data memory (MOVX) bus controller. Sits directly downstream of the DPTR register.

---
 rtl/bb8051_xdata_if.sv | 103 ++++++++++
 tb/tb_bb8051_xdata_if.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bb8051_xdata_if.sv
// rtl/bb8051_xdata_if.sv - MOVX external data memory bus controller
// Setup/strobe/hold bus cycle with programmable wait states, xwait stretch and timeout abort.
module bb8051_xdata_if #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        use_dptr,
    input  logic [7:0]  dptr_h,
    input  logic [7:0]  dptr_l,
    input  logic [7:0]  p2,
    input  logic [7:0]  ri,
    input  logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rd_data,
    output logic [15:0] xaddr,
    output logic [7:0]  xdata_out,
    output logic        xdata_oe,
    input  logic [7:0]  xdata_in,
    output logic        xrd_n,
    output logic        xwr_n,
    input  logic        xwait
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [7:0] WAIT_INIT = 8'(WAIT_STATES);
    localparam logic [7:0] TO_LIMIT  = 8'(TIMEOUT);

    state_t     state;
    state_t     state_nx;
    logic       we_q;
    logic       abort_q;
    logic [7:0] wait_cnt;
    logic [7:0] to_cnt;
    logic       cnt_zero;

    assign cnt_zero = (wait_cnt == 8'h00);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (req) state_nx = SETUP;
            SETUP:  state_nx = STROBE;
            // Abort fires on the stretch cycle that brings the timeout count up to TIMEOUT.
            STROBE: if (cnt_zero && (!xwait || to_cnt == TO_LIMIT - 8'd1)) state_nx = HOLD;
            HOLD:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            abort_q   <= 1'b0;
            wait_cnt  <= 8'h00;
            to_cnt    <= 8'h00;
            rd_data   <= 8'h00;
            xaddr     <= 16'h0000;
            xdata_out <= 8'h00;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q  <= we;
                        xaddr <= use_dptr ? {dptr_h, dptr_l} : {p2, ri};
                        if (we) xdata_out <= wr_data;
                    end
                end
                SETUP: begin
                    wait_cnt <= WAIT_INIT;
                    to_cnt   <= 8'h00;
                    abort_q  <= 1'b0;
                end
                STROBE: begin
                    if (!cnt_zero) wait_cnt <= wait_cnt - 8'd1;
                    else if (xwait) to_cnt <= to_cnt + 8'd1;
                    // Leaving with xwait still high can only mean the timeout abort.
                    if (state_nx == HOLD) begin
                        abort_q <= xwait;
                        if (!we_q) rd_data <= xwait ? 8'hFF : xdata_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == HOLD);
    assign err      = done && abort_q;
    assign xdata_oe = busy && we_q;
    assign xrd_n    = !((state == STROBE) && !we_q);
    assign xwr_n    = !((state == STROBE) && we_q);

endmodule

// File: tb/tb_bb8051_xdata_if.sv
// tb/tb_bb8051_xdata_if.sv - self-checking bench for bb8051_xdata_if
// Cycle-offset transaction model checked every cycle, plus directed literal scenarios.
module tb_bb8051_xdata_if;

    localparam int W  = 1;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0, use_dptr = 1'b0, xwait = 1'b0;
    logic [7:0]  dptr_h = 8'h00, dptr_l = 8'h00, p2 = 8'h00, ri = 8'h00;
    logic [7:0]  wr_data = 8'h00, xdata_in = 8'h00;
    logic        busy, done, err, xdata_oe, xrd_n, xwr_n;
    logic [7:0]  rd_data, xdata_out;
    logic [15:0] xaddr;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    bb8051_xdata_if #(.WAIT_STATES(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .use_dptr(use_dptr),
        .dptr_h(dptr_h), .dptr_l(dptr_l), .p2(p2), .ri(ri), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err), .rd_data(rd_data), .xaddr(xaddr),
        .xdata_out(xdata_out), .xdata_oe(xdata_oe), .xdata_in(xdata_in),
        .xrd_n(xrd_n), .xwr_n(xwr_n), .xwait(xwait)
    );

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Model: a transaction accepted at edge a shows SETUP after a, strobe from a+1,
    // and the strobe ends at the first count-zero cycle with xwait low, or after TO stretch cycles.
    bit          m_act = 0, m_we = 0, m_abort = 0, m_started = 0;
    int          m_a = 0, m_hold = 0, m_edge = 0;
    logic [15:0] m_addr = 16'h0;
    logic [7:0]  m_wd = 8'h0, m_rd = 8'h0;

    initial begin
        int  c, j;
        bit  e_done, strobe;
        forever begin
            @(negedge clk);
            if (m_started) begin
                e_done = m_act && m_hold != 0 && m_edge == m_hold;
                strobe = m_act && m_edge >= m_a + 1 && (m_hold == 0 || m_edge < m_hold);
                chk("cycle", 40'({busy, done, err, xdata_oe, xrd_n, xwr_n, rd_data, xdata_out, xaddr}),
                    40'({m_act, e_done, e_done && m_abort, m_act && m_we, !(strobe && !m_we),
                         !(strobe && m_we), m_rd, m_wd, m_addr}));
            end
            c = m_edge + 1;
            if (rst) begin
                m_act = 0; m_hold = 0; m_addr = 16'h0; m_wd = 8'h0; m_rd = 8'h0;
                m_we = 0; m_abort = 0; m_started = 1;
            end else if (m_act) begin
                if (m_hold == 0) begin
                    j = c - m_a - 2;
                    if (j >= W) begin
                        if (!xwait) begin
                            m_hold = c; m_abort = 0;
                            if (!m_we) m_rd = xdata_in;
                        end else if (j - W + 1 == TO) begin
                            m_hold = c; m_abort = 1;
                            if (!m_we) m_rd = 8'hFF;
                        end
                    end
                end else if (c == m_hold + 1) begin
                    m_act = 0;
                end
            end else if (req) begin
                m_act = 1; m_a = c; m_hold = 0; m_we = we;
                m_addr = use_dptr ? {dptr_h, dptr_l} : {p2, ri};
                if (we) m_wd = wr_data;
            end
            m_edge = c;
        end
    end

    task automatic issue(input bit w, input bit ud, input logic [15:0] ad, input logic [7:0] wd);
        we = w; use_dptr = ud; wr_data = wd;
        {dptr_h, dptr_l} = ud ? ad : 16'($urandom);
        {p2, ri}         = ud ? 16'($urandom) : ad;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        {dptr_h, dptr_l, p2, ri} = 32'($urandom);
    endtask

    task automatic observe(input int nst, input logic [7:0] din, input bit vary,
                           output int lat, output int rlo, output int wlo, output int oec,
                           output bit e, output logic [7:0] rd);
        lat = 0; rlo = 0; wlo = 0; oec = 0; e = 0; rd = 8'h00;
        for (int k = 1; k <= 40; k++) begin
            xwait    = (nst > 0) && (k < 3 + nst);
            xdata_in = vary ? din + 8'(k) : din;
            if (!xrd_n) rlo++;
            if (!xwr_n) wlo++;
            if (xdata_oe) oec++;
            if (done) begin
                lat = k; e = err; rd = rd_data;
                break;
            end
            @(posedge clk); #1;
        end
        xwait = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lat, rlo, wlo, oec, nd, d2, mode;
        bit e;
        logic [7:0] rd;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 40'({busy, done, err, xdata_oe, xrd_n, xwr_n, rd_data, xdata_out, xaddr}),
            40'({6'b000011, 8'h00, 8'h00, 16'h0000}));
        rst = 1'b0;
        @(posedge clk); #1;

        issue(1'b0, 1'b1, 16'h1234, 8'h00);
        observe(0, 8'hA5, 1'b0, lat, rlo, wlo, oec, e, rd);
        chk("rd_latency", 40'(lat), 40'd4);
        chk("rd_strobe_width", 40'(rlo), 40'd2);
        chk("rd_no_wr_strobe", 40'(wlo), 40'd0);
        chk("rd_data", 40'(rd), 40'hA5);
        chk("rd_xaddr", 40'(xaddr), 40'h1234);
        chk("rd_err", 40'(e), 40'd0);

        issue(1'b1, 1'b0, 16'h803C, 8'h5A);
        observe(0, 8'h00, 1'b1, lat, rlo, wlo, oec, e, rd);
        chk("wr_latency", 40'(lat), 40'd4);
        chk("wr_strobe_width", 40'(wlo), 40'd2);
        chk("wr_no_rd_strobe", 40'(rlo), 40'd0);
        chk("wr_oe_cycles", 40'(oec), 40'd4);
        chk("wr_xdata_out", 40'(xdata_out), 40'h5A);
        chk("wr_xaddr", 40'(xaddr), 40'h803C);

        issue(1'b0, 1'b1, 16'h4321, 8'h00);
        observe(TO - 1, 8'h40, 1'b1, lat, rlo, wlo, oec, e, rd);
        chk("stretch_latency", 40'(lat), 40'd7);
        chk("stretch_width", 40'(rlo), 40'd5);
        chk("stretch_rd_exit_edge", 40'(rd), 40'h46);
        chk("stretch_no_err", 40'(e), 40'd0);

        issue(1'b0, 1'b0, 16'h00FF, 8'h00);
        observe(99, 8'h33, 1'b0, lat, rlo, wlo, oec, e, rd);
        chk("timeout_latency", 40'(lat), 40'd7);
        chk("timeout_width", 40'(rlo), 40'd5);
        chk("timeout_err", 40'(e), 40'd1);
        chk("timeout_rd_ff", 40'(rd), 40'hFF);

        issue(1'b1, 1'b1, 16'hBEEF, 8'hC3);
        @(posedge clk); #1;
        chk("rst_pre_wr_strobe", 40'(xwr_n), 40'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_strobe", 40'({busy, done, err, xdata_oe, xrd_n, xwr_n, xaddr}),
            40'({6'b000011, 16'h0000}));
        rst = 1'b0;
        @(posedge clk); #1;
        issue(1'b0, 1'b1, 16'h0F0F, 8'h00);
        observe(0, 8'h77, 1'b0, lat, rlo, wlo, oec, e, rd);
        chk("post_rst_latency", 40'(lat), 40'd4);
        chk("post_rst_rd", 40'(rd), 40'h77);

        we = 1'b0; use_dptr = 1'b1; {dptr_h, dptr_l} = 16'h2000; xdata_in = 8'h11; xwait = 1'b0;
        req = 1'b1;
        @(posedge clk); #1;
        nd = 0; d2 = 0;
        for (int k = 1; k <= 12; k++) begin
            if (done) begin
                nd++;
                if (nd == 2) d2 = k;
            end
            if (k == 5) chk("b2b_idle_gap", 40'(busy), 40'd0);
            @(posedge clk); #1;
        end
        req = 1'b0;
        chk("b2b_done_count", 40'(nd), 40'd2);
        chk("b2b_second_done", 40'(d2), 40'd9);
        drain();

        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 60 == 0) mode = $urandom_range(0, 2);
            req      = ($urandom_range(0, 9) < 4);
            we       = 1'($urandom);
            use_dptr = 1'($urandom);
            {dptr_h, dptr_l, p2, ri} = 32'($urandom);
            wr_data  = 8'($urandom);
            xdata_in = 8'($urandom);
            xwait    = (mode == 0) ? 1'b0 :
                       (mode == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
            rst      = ($urandom_range(0, 249) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; req = 1'b0; xwait = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
